// File: rtl/latch_mem_wb_if.sv
// MEM/WB stage bundle: memory-stage results in, write-back controls out.
// The master side is the upstream memory stage; the slave side is the stage register.
interface latch_mem_wb_if #(
  parameter int len    = 32,
  parameter int NB_REG = 5,
  parameter int NB_CNT = 8
);
  logic              i_enable;
  logic              i_flush;
  logic              i_valid;
  logic [len-1:0]    i_read_data;
  logic [len-1:0]    i_alu_result;
  logic [len-1:0]    i_pc_link;
  logic [NB_REG-1:0] i_rd;
  logic              i_reg_write;
  logic              i_mem_to_reg;
  logic              i_link;
  logic [1:0]        i_load_size;
  logic              i_load_unsigned;

  logic [len-1:0]    o_wb_data;
  logic [NB_REG-1:0] o_rd;
  logic              o_reg_write;
  logic              o_valid;
  logic              o_misaligned;
  logic [NB_CNT-1:0] o_misaligned_count;

  modport master (
    output i_enable, i_flush, i_valid, i_read_data, i_alu_result, i_pc_link,
           i_rd, i_reg_write, i_mem_to_reg, i_link, i_load_size, i_load_unsigned,
    input  o_wb_data, o_rd, o_reg_write, o_valid, o_misaligned, o_misaligned_count
  );

  modport slave (
    input  i_enable, i_flush, i_valid, i_read_data, i_alu_result, i_pc_link,
           i_rd, i_reg_write, i_mem_to_reg, i_link, i_load_size, i_load_unsigned,
    output o_wb_data, o_rd, o_reg_write, o_valid, o_misaligned, o_misaligned_count
  );
endinterface

// File: rtl/latch_mem_wb.sv
// MEM/WB pipeline register: narrows/extends loads, selects the write-back source,
// suppresses and counts misaligned loads. All outputs are registered.
module latch_mem_wb #(
  parameter int len    = 32,
  parameter int NB_REG = 5,
  parameter int NB_CNT = 8
) (
  input  logic           i_clk,
  input  logic           i_rst,
  latch_mem_wb_if.slave  bus
);

  localparam logic [1:0] SIZE_BYTE = 2'b00;
  localparam logic [1:0] SIZE_HALF = 2'b01;

  logic [1:0]        off;
  logic [7:0]        byte_lane [4];
  logic [7:0]        byte_sel;
  logic [15:0]       half_sel;
  logic [len-1:0]    load_value;
  logic              is_load;
  logic              misaligned;

  logic [len-1:0]    wb_data_reg,    wb_data_next;
  logic [NB_REG-1:0] rd_reg,         rd_next;
  logic              reg_write_reg,  reg_write_next;
  logic              valid_reg,      valid_next;
  logic              misaligned_reg, misaligned_next;
  logic [NB_CNT-1:0] count_reg,      count_next;

  assign off = bus.i_alu_result[1:0];

  // Little-endian lanes: byte k of the RAM word sits at bits [8k+7:8k].
  genvar gi;
  generate
    for (gi = 0; gi < 4; gi++) begin : g_lane
      assign byte_lane[gi] = bus.i_read_data[8*gi +: 8];
    end
  endgenerate

  assign byte_sel = byte_lane[off];
  assign half_sel = off[1] ? bus.i_read_data[31:16] : bus.i_read_data[15:0];

  always_comb begin
    load_value = bus.i_read_data;
    case (bus.i_load_size)
      SIZE_BYTE: load_value = {{(len-8){~bus.i_load_unsigned & byte_sel[7]}}, byte_sel};
      SIZE_HALF: load_value = {{(len-16){~bus.i_load_unsigned & half_sel[15]}}, half_sel};
      default:   load_value = bus.i_read_data;
    endcase
  end

  // Size 11 is treated as a word, so any non-zero offset on size[1] is misaligned.
  assign is_load    = bus.i_valid & bus.i_mem_to_reg;
  assign misaligned = is_load &
                      (((bus.i_load_size == SIZE_HALF) & off[0]) |
                       (bus.i_load_size[1] & (off != 2'b00)));

  always_comb begin
    wb_data_next    = wb_data_reg;
    rd_next         = rd_reg;
    reg_write_next  = reg_write_reg;
    valid_next      = valid_reg;
    misaligned_next = misaligned_reg;
    count_next      = count_reg;
    if (bus.i_flush) begin
      wb_data_next    = '0;
      rd_next         = '0;
      reg_write_next  = 1'b0;
      valid_next      = 1'b0;
      misaligned_next = 1'b0;
    end else if (bus.i_enable) begin
      if (bus.i_link)
        wb_data_next = bus.i_pc_link;
      else if (bus.i_mem_to_reg)
        wb_data_next = load_value;
      else
        wb_data_next = bus.i_alu_result;
      rd_next         = bus.i_rd;
      reg_write_next  = bus.i_valid & bus.i_reg_write & (bus.i_rd != '0) & ~misaligned;
      valid_next      = bus.i_valid;
      misaligned_next = misaligned;
      // Counted only on the capturing edge, so a stall never re-counts the same load.
      if (misaligned && (count_reg != {NB_CNT{1'b1}}))
        count_next = count_reg + NB_CNT'(1);
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      wb_data_reg    <= '0;
      rd_reg         <= '0;
      reg_write_reg  <= 1'b0;
      valid_reg      <= 1'b0;
      misaligned_reg <= 1'b0;
      count_reg      <= '0;
    end else begin
      wb_data_reg    <= wb_data_next;
      rd_reg         <= rd_next;
      reg_write_reg  <= reg_write_next;
      valid_reg      <= valid_next;
      misaligned_reg <= misaligned_next;
      count_reg      <= count_next;
    end
  end

  assign bus.o_wb_data          = wb_data_reg;
  assign bus.o_rd               = rd_reg;
  assign bus.o_reg_write        = reg_write_reg;
  assign bus.o_valid            = valid_reg;
  assign bus.o_misaligned       = misaligned_reg;
  assign bus.o_misaligned_count = count_reg;

endmodule

// File: tb/tb_latch_mem_wb.sv
// Directed bench for latch_mem_wb: load extraction, write-back selection, stalls,
// flush, misalignment counting with saturation, and mid-stream reset.
module tb_latch_mem_wb;

  logic i_clk;
  logic i_rst;
  int   n_checks;
  int   n_fails;
  int   cnt_model;

  latch_mem_wb_if #(.len(32), .NB_REG(5), .NB_CNT(8)) bus ();

  latch_mem_wb #(.len(32), .NB_REG(5), .NB_CNT(8)) dut (
    .i_clk (i_clk),
    .i_rst (i_rst),
    .bus   (bus.slave)
  );

  initial i_clk = 1'b0;
  always #5 i_clk = ~i_clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fails++;
      $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
    end
  endtask

  task automatic check_all(input string tag, input logic [31:0] wb, input logic [4:0] rd,
                           input logic rw, input logic vld, input logic mis, input logic [7:0] cnt);
    check({tag, ".wb"},  bus.o_wb_data, wb);
    check({tag, ".rd"},  32'(bus.o_rd), 32'(rd));
    check({tag, ".rw"},  32'(bus.o_reg_write), 32'(rw));
    check({tag, ".vld"}, 32'(bus.o_valid), 32'(vld));
    check({tag, ".mis"}, 32'(bus.o_misaligned), 32'(mis));
    check({tag, ".cnt"}, 32'(bus.o_misaligned_count), 32'(cnt));
    $display("txn %-10s wb=%08h rd=%0d rw=%0b v=%0b mis=%0b cnt=%0d", tag, bus.o_wb_data,
             bus.o_rd, bus.o_reg_write, bus.o_valid, bus.o_misaligned, bus.o_misaligned_count);
  endtask

  // Load instruction: valid, mem_to_reg, reg_write set.
  task automatic drive_load(input logic [1:0] size, input logic uns, input logic [31:0] addr,
                            input logic [31:0] data, input logic [4:0] rd);
    bus.i_valid = 1'b1; bus.i_reg_write = 1'b1; bus.i_mem_to_reg = 1'b1; bus.i_link = 1'b0;
    bus.i_load_size = size; bus.i_load_unsigned = uns;
    bus.i_alu_result = addr; bus.i_read_data = data; bus.i_rd = rd;
    bus.i_pc_link = 32'h0000_1000;
  endtask

  task automatic drive_alu(input logic [31:0] res, input logic [4:0] rd, input logic link,
                           input logic [31:0] pcl);
    bus.i_valid = 1'b1; bus.i_reg_write = 1'b1; bus.i_mem_to_reg = 1'b0; bus.i_link = link;
    bus.i_load_size = 2'b10; bus.i_load_unsigned = 1'b0;
    bus.i_alu_result = res; bus.i_read_data = 32'hA5A5_A5A5; bus.i_rd = rd;
    bus.i_pc_link = pcl;
  endtask

  task automatic tick();
    @(posedge i_clk);
    #1;
  endtask

  initial begin
    n_checks = 0;
    n_fails  = 0;
    i_rst = 1'b1;
    bus.i_enable = 1'b1; bus.i_flush = 1'b0;
    drive_load(2'b10, 1'b0, 32'h0000_0001, 32'h1234_5678, 5'd7);
    tick(); tick();
    check_all("reset", 32'h0, 5'd0, 1'b0, 1'b0, 1'b0, 8'd0);
    i_rst = 1'b0;

    // Byte loads, signed then unsigned.
    drive_load(2'b00, 1'b0, 32'h0000_0100, 32'h80FF_7F01, 5'd3); tick();
    check_all("lb_off0", 32'h0000_0001, 5'd3, 1'b1, 1'b1, 1'b0, 8'd0);
    drive_load(2'b00, 1'b0, 32'h0000_0101, 32'h80FF_7F01, 5'd3); tick();
    check_all("lb_off1", 32'h0000_007F, 5'd3, 1'b1, 1'b1, 1'b0, 8'd0);
    drive_load(2'b00, 1'b0, 32'h0000_0102, 32'h80FF_7F01, 5'd3); tick();
    check_all("lb_off2", 32'hFFFF_FFFF, 5'd3, 1'b1, 1'b1, 1'b0, 8'd0);
    drive_load(2'b00, 1'b0, 32'h0000_0103, 32'h80FF_7F01, 5'd3); tick();
    check_all("lb_off3", 32'hFFFF_FF80, 5'd3, 1'b1, 1'b1, 1'b0, 8'd0);
    drive_load(2'b00, 1'b1, 32'h0000_0103, 32'h80FF_7F01, 5'd3); tick();
    check_all("lbu_off3", 32'h0000_0080, 5'd3, 1'b1, 1'b1, 1'b0, 8'd0);

    // Halfword loads; offset 1 is misaligned, the low half is still extracted.
    drive_load(2'b01, 1'b0, 32'h0000_0202, 32'h8001_1234, 5'd5); tick();
    check_all("lh_off2", 32'hFFFF_8001, 5'd5, 1'b1, 1'b1, 1'b0, 8'd0);
    drive_load(2'b01, 1'b1, 32'h0000_0202, 32'h8001_1234, 5'd5); tick();
    check_all("lhu_off2", 32'h0000_8001, 5'd5, 1'b1, 1'b1, 1'b0, 8'd0);
    drive_load(2'b01, 1'b0, 32'h0000_0201, 32'h8001_1234, 5'd5); tick();
    check_all("lh_off1", 32'h0000_1234, 5'd5, 1'b0, 1'b1, 1'b1, 8'd1);

    // ALU result to r0 is never written; link takes priority.
    drive_alu(32'h0000_0055, 5'd0, 1'b0, 32'h0); tick();
    check_all("alu_r0", 32'h0000_0055, 5'd0, 1'b0, 1'b1, 1'b0, 8'd1);
    drive_alu(32'h0000_0055, 5'd9, 1'b1, 32'h0000_0040); tick();
    check_all("link_r9", 32'h0000_0040, 5'd9, 1'b1, 1'b1, 1'b0, 8'd1);

    // Aligned LW, then a three-cycle stall with changing inputs.
    drive_load(2'b10, 1'b0, 32'h0000_0100, 32'hDEAD_BEEF, 5'd4); tick();
    check_all("lw", 32'hDEAD_BEEF, 5'd4, 1'b1, 1'b1, 1'b0, 8'd1);
    bus.i_enable = 1'b0;
    for (int k = 0; k < 3; k++) begin
      drive_load(2'(k), 1'b1, 32'h0000_0301 + k, 32'h0BAD_0000 + k, 5'(k + 20));
      tick();
      check_all($sformatf("hold%0d", k), 32'hDEAD_BEEF, 5'd4, 1'b1, 1'b1, 1'b0, 8'd1);
    end

    // Misaligned LW (size 11), stalled: pulse stretches, counted once.
    bus.i_enable = 1'b1;
    drive_load(2'b11, 1'b0, 32'h0000_0102, 32'hCAFE_F00D, 5'd6); tick();
    check_all("lw_mis", 32'hCAFE_F00D, 5'd6, 1'b0, 1'b1, 1'b1, 8'd2);
    bus.i_enable = 1'b0;
    tick();
    check_all("mis_hold0", 32'hCAFE_F00D, 5'd6, 1'b0, 1'b1, 1'b1, 8'd2);
    tick();
    check_all("mis_hold1", 32'hCAFE_F00D, 5'd6, 1'b0, 1'b1, 1'b1, 8'd2);

    // Flush wins over enable; counter holds even with a misaligned input present.
    bus.i_enable = 1'b1; bus.i_flush = 1'b1;
    tick();
    check_all("flush", 32'h0, 5'd0, 1'b0, 1'b0, 1'b0, 8'd2);
    bus.i_flush = 1'b0;

    // Invalid misaligned load is neither flagged nor counted.
    drive_load(2'b10, 1'b0, 32'h0000_0103, 32'h1111_2222, 5'd8);
    bus.i_valid = 1'b0; tick();
    check("inv.vld", 32'(bus.o_valid), 32'd0);
    check("inv.rw",  32'(bus.o_reg_write), 32'd0);
    check("inv.mis", 32'(bus.o_misaligned), 32'd0);
    check("inv.cnt", 32'(bus.o_misaligned_count), 32'd2);
    $display("txn invalid    v=%0b mis=%0b cnt=%0d", bus.o_valid, bus.o_misaligned,
             bus.o_misaligned_count);

    // 260 back-to-back misaligned LW: count saturates at 255, pulse persists.
    cnt_model = 2;
    for (int k = 0; k < 260; k++) begin
      drive_load(2'b10, 1'b0, 32'h0000_0401 + 32'(k % 3), 32'h0000_0000 + k, 5'd10);
      tick();
      cnt_model = (cnt_model == 255) ? 255 : cnt_model + 1;
      check($sformatf("sat%0d.cnt", k), 32'(bus.o_misaligned_count), 32'(cnt_model));
      check($sformatf("sat%0d.mis", k), 32'(bus.o_misaligned), 32'd1);
      $display("txn sat%-6d mis=%0b cnt=%0d", k, bus.o_misaligned, bus.o_misaligned_count);
    end

    // Reset mid-stream beats flush and enable.
    i_rst = 1'b1; bus.i_flush = 1'b1;
    tick();
    check_all("mid_rst", 32'h0, 5'd0, 1'b0, 1'b0, 1'b0, 8'd0);
    i_rst = 1'b0; bus.i_flush = 1'b0;
    drive_load(2'b01, 1'b0, 32'h0000_0003, 32'h7FFF_0000, 5'd11); tick();
    check_all("post_rst", 32'h0000_7FFF, 5'd11, 1'b0, 1'b1, 1'b1, 8'd1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout simulation did not finish");
    $fatal(1, "timeout");
  end

endmodule
